// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - out-of-order ALU issue queue with CDB wakeup and oldest-ready select
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kill all entries and discard this cycle's select
//   disp_*              dispatch micro-op (valid/ready handshake, opcode, tags, ready bits, values)
//   cdb_valid/tag/val   wakeup broadcast
//   alu_en, opcode,     registered issue outputs driving the ALU
//   val1, val2,
//   alu_dst_tag
//   iq_count            number of occupied entries

package alu_issue_queue_pkg;
    typedef enum logic [3:0] {
        ADD_I  = 4'd0,
        SUB_I  = 4'd1,
        AND_I  = 4'd2,
        OR_I   = 4'd3,
        XOR_I  = 4'd4,
        SLL_I  = 4'd5,
        SRL_I  = 4'd6,
        SRA_I  = 4'd7,
        SLT_I  = 4'd8,
        SLTU_I = 4'd9,
        BEQ_I  = 4'd10,
        BNE_I  = 4'd11,
        BLT_I  = 4'd12,
        BGE_I  = 4'd13
    } instr_opcode;
endpackage

module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  instr_opcode                  disp_opcode,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic [TAG_W-1:0]             disp_src1_tag,
    input  logic [TAG_W-1:0]             disp_src2_tag,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic [XLEN-1:0]              disp_src1_val,
    input  logic [XLEN-1:0]              disp_src2_val,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [XLEN-1:0]              cdb_val,
    output logic                         alu_en,
    output instr_opcode                  opcode,
    output logic [XLEN-1:0]              val1,
    output logic [XLEN-1:0]              val2,
    output logic [TAG_W-1:0]             alu_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0]   iq_count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic              valid;
        instr_opcode       op;
        logic [TAG_W-1:0]  dst;
        logic [TAG_W-1:0]  t1;
        logic              r1;
        logic [XLEN-1:0]   v1;
        logic [TAG_W-1:0]  t2;
        logic              r2;
        logic [XLEN-1:0]   v2;
    } entry_t;

    entry_t             q_q [DEPTH];
    entry_t             q_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;

    logic               issue;
    logic [DEPTH-1:0]   shift;
    instr_opcode        sel_op;
    logic [TAG_W-1:0]   sel_dst;
    logic [XLEN-1:0]    sel_v1, sel_v2;

    entry_t             disp_e;
    logic               disp_fire;
    logic [CNT_W-1:0]   wr_idx;

    logic               alu_en_q;
    instr_opcode        opcode_q;
    logic [XLEN-1:0]    val1_q, val2_q;
    logic [TAG_W-1:0]   dst_q;

    // Oldest-ready select on registered state only. shift[i] marks every
    // slot at or above the selected one; those slots take their upper
    // neighbour's contents when the selected entry leaves.
    always_comb begin
        issue   = 1'b0;
        shift   = '0;
        sel_op  = q_q[0].op;
        sel_dst = q_q[0].dst;
        sel_v1  = q_q[0].v1;
        sel_v2  = q_q[0].v2;
        for (int i = 0; i < DEPTH; i++) begin
            if (!issue && q_q[i].valid && q_q[i].r1 && q_q[i].r2) begin
                issue   = 1'b1;
                sel_op  = q_q[i].op;
                sel_dst = q_q[i].dst;
                sel_v1  = q_q[i].v1;
                sel_v2  = q_q[i].v2;
            end
            shift[i] = issue;
        end
    end

    // Ready does not look at the select, keeping select off the dispatch path.
    assign disp_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign wr_idx     = count_q - CNT_W'(issue);

    // Incoming op, with same-cycle CDB bypass for sources not yet ready.
    always_comb begin
        disp_e       = '0;
        disp_e.valid = 1'b1;
        disp_e.op    = disp_opcode;
        disp_e.dst   = disp_dst_tag;
        disp_e.t1    = disp_src1_tag;
        disp_e.t2    = disp_src2_tag;
        disp_e.r1    = disp_src1_rdy || (cdb_valid && (cdb_tag == disp_src1_tag));
        disp_e.r2    = disp_src2_rdy || (cdb_valid && (cdb_tag == disp_src2_tag));
        disp_e.v1    = disp_src1_rdy ? disp_src1_val : cdb_val;
        disp_e.v2    = disp_src2_rdy ? disp_src2_val : cdb_val;
    end

    // Next queue state: compact, then wake up, then append, then flush.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (shift[i]) begin
                q_d[i] = q_q[i+1];
            end
        end
        if (shift[DEPTH-1]) begin
            q_d[DEPTH-1].valid = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && q_d[i].valid) begin
                if (!q_d[i].r1 && (q_d[i].t1 == cdb_tag)) begin
                    q_d[i].r1 = 1'b1;
                    q_d[i].v1 = cdb_val;
                end
                if (!q_d[i].r2 && (q_d[i].t2 == cdb_tag)) begin
                    q_d[i].r2 = 1'b1;
                    q_d[i].v2 = cdb_val;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && (CNT_W'(i) == wr_idx)) begin
                q_d[i] = disp_e;
            end
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_d[i].valid = 1'b0;
            end
        end

        count_d = flush ? '0 : (count_q - CNT_W'(issue) + CNT_W'(disp_fire));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
            count_q  <= '0;
            alu_en_q <= 1'b0;
            opcode_q <= instr_opcode'(0);
            val1_q   <= '0;
            val2_q   <= '0;
            dst_q    <= '0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            if (issue && !flush) begin
                alu_en_q <= 1'b1;
                opcode_q <= sel_op;
                val1_q   <= sel_v1;
                val2_q   <= sel_v2;
                dst_q    <= sel_dst;
            end else begin
                alu_en_q <= 1'b0;
            end
        end
    end

    assign alu_en      = alu_en_q;
    assign opcode      = opcode_q;
    assign val1        = val1_q;
    assign val2        = val2_q;
    assign alu_dst_tag = dst_q;
    assign iq_count    = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - self-checking bench for alu_issue_queue
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              disp_valid = 1'b0;
    logic              disp_ready;
    instr_opcode       disp_opcode = ADD_I;
    logic [TAG_W-1:0]  disp_dst_tag = '0;
    logic [TAG_W-1:0]  disp_src1_tag = '0;
    logic [TAG_W-1:0]  disp_src2_tag = '0;
    logic              disp_src1_rdy = 1'b0;
    logic              disp_src2_rdy = 1'b0;
    logic [XLEN-1:0]   disp_src1_val = '0;
    logic [XLEN-1:0]   disp_src2_val = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [XLEN-1:0]   cdb_val = '0;
    logic              alu_en;
    instr_opcode       opcode;
    logic [XLEN-1:0]   val1, val2;
    logic [TAG_W-1:0]  alu_dst_tag;
    logic [2:0]        iq_count;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
        .disp_dst_tag(disp_dst_tag), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .alu_en(alu_en), .opcode(opcode), .val1(val1), .val2(val2),
        .alu_dst_tag(alu_dst_tag), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, flush, dv;
        instr_opcode op;
        logic [5:0] dst, t1;
        logic r1;
        logic [31:0] v1;
        logic [5:0] t2;
        logic r2;
        logic [31:0] v2;
        logic cv;
        logic [5:0] ct;
        logic [31:0] cval;
    } in_t;

    typedef struct {
        in_t i;
        logic e_rdy, e_en;
        instr_opcode e_op;
        logic [31:0] e_v1, e_v2;
        logic [5:0] e_dst;
        logic [2:0] e_cnt;
    } vec_t;

    // Reference model: an age-ordered list of waiting ops.
    typedef struct {
        instr_opcode op;
        logic [5:0] dst, t1, t2;
        logic r1, r2;
        logic [31:0] v1, v2;
    } m_ent;

    m_ent        mq[$];
    logic        m_en;
    instr_opcode m_op;
    logic [31:0] m_v1, m_v2;
    logic [5:0]  m_dst;

    int   checks = 0;
    int   errors = 0;
    logic obs_rdy;
    vec_t vt[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(in_t s, logic can_disp);
        if (s.rst) begin
            mq.delete();
            m_en = 1'b0; m_op = instr_opcode'(0); m_v1 = '0; m_v2 = '0; m_dst = '0;
        end else if (s.flush) begin
            mq.delete();
            m_en = 1'b0;
        end else begin
            int   hit;
            m_ent n;
            hit = -1;
            foreach (mq[k]) if (hit < 0 && mq[k].r1 && mq[k].r2) hit = k;
            if (hit >= 0) begin
                m_en = 1'b1; m_op = mq[hit].op; m_v1 = mq[hit].v1; m_v2 = mq[hit].v2; m_dst = mq[hit].dst;
                mq.delete(hit);
            end else begin
                m_en = 1'b0;
            end
            foreach (mq[k]) begin
                if (s.cv && !mq[k].r1 && mq[k].t1 == s.ct) begin mq[k].r1 = 1'b1; mq[k].v1 = s.cval; end
                if (s.cv && !mq[k].r2 && mq[k].t2 == s.ct) begin mq[k].r2 = 1'b1; mq[k].v2 = s.cval; end
            end
            if (s.dv && can_disp) begin
                n.op = s.op; n.dst = s.dst; n.t1 = s.t1; n.t2 = s.t2;
                n.r1 = s.r1 || (s.cv && s.ct == s.t1);
                n.r2 = s.r2 || (s.cv && s.ct == s.t2);
                n.v1 = s.r1 ? s.v1 : s.cval;
                n.v2 = s.r2 ? s.v2 : s.cval;
                mq.push_back(n);
            end
        end
    endtask

    task automatic step(in_t s);
        logic exp_rdy;
        @(negedge clk);
        rst = s.rst; flush = s.flush; disp_valid = s.dv; disp_opcode = s.op;
        disp_dst_tag = s.dst; disp_src1_tag = s.t1; disp_src1_rdy = s.r1; disp_src1_val = s.v1;
        disp_src2_tag = s.t2; disp_src2_rdy = s.r2; disp_src2_val = s.v2;
        cdb_valid = s.cv; cdb_tag = s.ct; cdb_val = s.cval;
        #1;
        exp_rdy = !s.rst && (mq.size() < DEPTH);
        obs_rdy = disp_ready;
        chk("m_disp_ready", disp_ready, exp_rdy);
        model_edge(s, exp_rdy);
        @(posedge clk);
        #1;
        chk("m_alu_en", alu_en, m_en);
        chk("m_opcode", opcode, m_op);
        chk("m_val1", val1, m_v1);
        chk("m_val2", val2, m_v2);
        chk("m_dst", alu_dst_tag, m_dst);
        chk("m_iq_count", iq_count, mq.size());
        checks++;
        assert (iq_count <= 3'(DEPTH)) else begin
            errors++;
            $display("FAIL iq_count_bound actual=%0d required<=%0d", iq_count, DEPTH);
        end
    endtask

    function automatic in_t nop();
        in_t s;
        s.rst = 0; s.flush = 0; s.dv = 0; s.op = ADD_I; s.dst = 0;
        s.t1 = 0; s.r1 = 0; s.v1 = 0; s.t2 = 0; s.r2 = 0; s.v2 = 0;
        s.cv = 0; s.ct = 0; s.cval = 0;
        return s;
    endfunction

    function automatic in_t D(instr_opcode op, logic [5:0] dst, logic [5:0] t1, logic r1, logic [31:0] v1,
                              logic [5:0] t2, logic r2, logic [31:0] v2);
        in_t s;
        s = nop();
        s.dv = 1; s.op = op; s.dst = dst; s.t1 = t1; s.r1 = r1; s.v1 = v1; s.t2 = t2; s.r2 = r2; s.v2 = v2;
        return s;
    endfunction

    function automatic in_t C(in_t s, logic [5:0] ct, logic [31:0] cval);
        in_t r;
        r = s; r.cv = 1; r.ct = ct; r.cval = cval;
        return r;
    endfunction

    task automatic row(in_t s, logic rdy, logic en, instr_opcode op, logic [31:0] v1, logic [31:0] v2,
                       logic [5:0] dst, logic [2:0] cnt);
        vec_t v;
        v.i = s; v.e_rdy = rdy; v.e_en = en; v.e_op = op; v.e_v1 = v1; v.e_v2 = v2; v.e_dst = dst; v.e_cnt = cnt;
        vt.push_back(v);
    endtask

    initial begin
        in_t s;
        // Directed table: disp_ready sampled before the edge, the rest after it.
        s = nop(); s.rst = 1;
        row(s, 0, 0, ADD_I, 0, 0, 0, 0);
        row(D(ADD_I, 3, 1, 1, 5, 2, 1, 7),               1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 1, ADD_I, 5, 7, 3, 0);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 0);
        row(D(SUB_I, 10, 9, 0, 0, 0, 1, 1),              1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 1);
        row(C(nop(), 9, 32'h20),                         1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 1, SUB_I, 32'h20, 1, 10, 0);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 0);
        row(D(OR_I, 20, 4, 0, 0, 0, 1, 3),               1, 0, ADD_I, 0, 0, 0, 1);
        row(D(XOR_I, 21, 0, 1, 32'h11, 0, 1, 32'h22),    1, 0, ADD_I, 0, 0, 0, 2);
        row(D(AND_I, 22, 0, 1, 32'hF0, 0, 1, 32'h3C),    1, 1, XOR_I, 32'h11, 32'h22, 21, 2);
        row(nop(),                                       1, 1, AND_I, 32'hF0, 32'h3C, 22, 1);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 1);
        row(C(nop(), 4, 32'h44),                         1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 1, OR_I, 32'h44, 3, 20, 0);
        row(D(ADD_I, 40, 30, 0, 0, 0, 1, 1),             1, 0, ADD_I, 0, 0, 0, 1);
        row(D(SUB_I, 41, 31, 0, 0, 0, 1, 2),             1, 0, ADD_I, 0, 0, 0, 2);
        row(D(AND_I, 42, 32, 0, 0, 0, 1, 3),             1, 0, ADD_I, 0, 0, 0, 3);
        row(D(OR_I, 43, 33, 0, 0, 0, 1, 4),              1, 0, ADD_I, 0, 0, 0, 4);
        row(C(nop(), 30, 32'h30),                        0, 0, ADD_I, 0, 0, 0, 4);
        row(D(XOR_I, 50, 0, 1, 1, 0, 1, 1),              0, 1, ADD_I, 32'h30, 1, 40, 3);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 3);
        row(C(nop(), 31, 32'h31),                        1, 0, ADD_I, 0, 0, 0, 3);
        s = D(XOR_I, 51, 0, 1, 1, 0, 1, 1); s.flush = 1;
        row(s,                                           1, 0, ADD_I, 0, 0, 0, 0);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 0);
        row(C(D(ADD_I, 55, 12, 0, 0, 0, 1, 2), 12, 32'hAB), 1, 0, ADD_I, 0, 0, 0, 1);
        row(nop(),                                       1, 1, ADD_I, 32'hAB, 2, 55, 0);
        row(D(SUB_I, 60, 0, 1, 9, 0, 1, 8),              1, 0, ADD_I, 0, 0, 0, 1);
        row(D(AND_I, 61, 0, 1, 7, 0, 1, 6),              1, 1, SUB_I, 9, 8, 60, 1);
        s = D(OR_I, 62, 0, 1, 5, 0, 1, 5); s.rst = 1;
        row(s,                                           0, 0, ADD_I, 0, 0, 0, 0);
        row(nop(),                                       1, 0, ADD_I, 0, 0, 0, 0);

        foreach (vt[k]) begin
            step(vt[k].i);
            chk($sformatf("row%0d_disp_ready", k), obs_rdy, vt[k].e_rdy);
            chk($sformatf("row%0d_alu_en", k), alu_en, vt[k].e_en);
            chk($sformatf("row%0d_iq_count", k), iq_count, vt[k].e_cnt);
            if (vt[k].e_en || vt[k].i.rst) begin
                chk($sformatf("row%0d_opcode", k), opcode, vt[k].e_op);
                chk($sformatf("row%0d_val1", k), val1, vt[k].e_v1);
                chk($sformatf("row%0d_val2", k), val2, vt[k].e_v2);
                chk($sformatf("row%0d_dst", k), alu_dst_tag, vt[k].e_dst);
            end
        end

        // Random traffic against the model; small tag space so CDB hits often.
        for (int c = 0; c < 3000; c++) begin
            s = nop();
            s.rst   = ($urandom_range(0, 99) == 0);
            s.flush = ($urandom_range(0, 39) == 0);
            s.dv    = ($urandom_range(0, 1) == 1);
            s.op    = instr_opcode'($urandom_range(0, 13));
            s.dst   = 6'($urandom);
            s.t1    = 6'($urandom_range(1, 7));
            s.r1    = ($urandom_range(0, 2) != 0);
            s.v1    = $urandom;
            s.t2    = 6'($urandom_range(1, 7));
            s.r2    = ($urandom_range(0, 2) != 0);
            s.v2    = $urandom;
            s.cv    = ($urandom_range(0, 2) == 0);
            s.ct    = 6'($urandom_range(1, 7));
            s.cval  = $urandom;
            step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Out-of-order issue queue that feeds the integer ALU execute stage.
- Accepts renamed ALU/branch micro-ops from dispatch.
- Captures source operands from dispatch or from common-data-bus (CDB) wakeup broadcasts.
- Each cycle, issues the oldest entry with both operands ready, through registered outputs that drive the ALU's alu_en/opcode/val1/val2 inputs directly.

Parameters:
- DEPTH, 4, number of queue entries (2..16).
- TAG_W, 6, physical-register tag width.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all entries and the pending issue (branch mispredict)
- disp_valid  in  1  dispatch micro-op valid
- disp_ready  out  1  queue can accept (combinational)
- disp_opcode  in  instr_opcode  operation
- disp_dst_tag  in  TAG_W  destination tag
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags
- disp_src1_rdy, disp_src2_rdy  in  1  source value already available
- disp_src1_val, disp_src2_val  in  XLEN  source values (src2 carries the immediate for I-type, with src2_rdy=1)
- cdb_valid  in  1  wakeup broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_val  in  XLEN  broadcast value
- alu_en  out  1  issued op valid (registered)
- opcode  out  instr_opcode  issued opcode (registered)
- val1, val2  out  XLEN  issued operands (registered)
- alu_dst_tag  out  TAG_W  issued destination tag (registered)
- iq_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- **Storage.** Collapsing queue; index 0 is the oldest.
  - Each entry holds valid, opcode, dst_tag, src1/src2 tag, rdy and val.
  - Valid entries are always contiguous from index 0.
- **Reset (rst=1 at posedge).**
  - All entries invalid; iq_count=0.
  - alu_en=0; opcode = value 0 of instr_opcode; val1=val2=0; alu_dst_tag=0.
  - disp_ready=0 while rst is high, and 1 the cycle after reset deasserts.
  - Reset overrides flush and all other inputs.
- **Dispatch.**
  - disp_ready = !rst && (iq_count < DEPTH). It does not depend on a same-cycle issue, so there is no path from the select logic.
  - Handshake when disp_valid && disp_ready at a posedge: the op is written at index (iq_count - issued_this_cycle).
- **Wakeup.**
  - When cdb_valid and cdb_tag equals the tag of a valid, not-ready source, that source sets rdy=1 and captures cdb_val at the posedge.
  - Applies to both sources of every entry simultaneously.
  - Same-cycle bypass: a dispatching source with rdy=0 whose tag matches a valid CDB tag is written as ready with cdb_val.
  - Sources already ready ignore CDB.
- **Select.**
  - Eligible entry = valid && src1_rdy && src2_rdy, using registered state only. An entry woken at edge E is first eligible in the cycle after E.
  - Pick the lowest eligible index.
  - At the posedge: the output registers load its opcode/vals/dst_tag with alu_en=1; the entry is removed; higher entries shift down one.
  - With no eligible entry: alu_en=0 and the other outputs hold their previous values.
  - At most one issue per cycle.
- **Latency.**
  - Op dispatched at edge E with both sources ready → alu_en=1 in the cycle after edge E+1 (2-cycle minimum).
  - Wakeup at edge E → issue registers load at E+1 at the earliest.
- **Simultaneous events.**
  - Dispatch + issue in the same cycle: compaction is applied first, then the append; iq_count is unchanged.
  - CDB + dispatch + issue in the same cycle: all apply. Wakeup values land in the post-shift positions.
  - CDB tag matching a source of the entry being issued this cycle has no effect; that entry was already fully ready.
- **Flush.**
  - At the posedge: all entries invalid, iq_count=0, alu_en=0.
  - Any dispatch in the flush cycle is dropped; any select in that cycle is discarded.
  - disp_ready is unaffected in the flush cycle itself.
- **Full.**
  - iq_count=DEPTH forces disp_ready=0.
  - An issue in that cycle frees a slot for dispatch in the next cycle.
- **Invariant.** iq_count never exceeds DEPTH or underflows; the bench checks this as an assertion.

Test Plan:
- Reset then dispatch ADD_I with src1=5/rdy, src2=7/rdy, dst_tag=3 → alu_en=1 two cycles later with opcode=ADD_I, val1=5, val2=7, alu_dst_tag=3; alu_en=0 in all other cycles.
- Dispatch SUB_I with src1 tag 9 not ready, src2=1/rdy; CDB broadcasts tag 9, value 0x20 three cycles later → issue in the cycle after the CDB edge with val1=0x20; no issue before that.
- Dispatch A (waiting on tag 4), then B (ready), then C (ready) → B issues, then C; A issues only after CDB tag 4. Remaining entries compact correctly and order is preserved.
- Fill DEPTH=4 entries, all blocked → disp_ready=0 and iq_count=4. CDB wakes entry 0 → entry 0 issues, the same-cycle dispatch is refused, disp_ready=1 in the following cycle.
- Dispatch a not-ready source with tag 12 in the same cycle as CDB tag 12, value 0xAB → entry is captured ready and issues two cycles later with val1=0xAB.
- Queue holding 3 entries plus a pending issue, then flush=1 → next cycle iq_count=0 and alu_en=0; the dispatch in the flush cycle is dropped. Repeat with rst asserted mid-operation → all outputs return to their reset values.
